// File: rtl/lcd_byte_writer_if.sv
// Write handshake between the LCD init/refresh sequencer and the byte writer,
// bundled with the character LCD 4-bit bus pins that the writer drives.
interface lcd_byte_writer_if;
    logic       wr_enable;
    logic       rs_in;
    logic [7:0] data_in;
    logic       nibble_only;
    logic       busy;
    logic       wr_finish;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_db;

    modport master (
        output wr_enable, rs_in, data_in, nibble_only,
        input  busy, wr_finish, lcd_e, lcd_rs, lcd_rw, lcd_db
    );

    modport slave (
        input  wr_enable, rs_in, data_in, nibble_only,
        output busy, wr_finish, lcd_e, lcd_rs, lcd_rw, lcd_db
    );
endinterface

// File: rtl/lcd_byte_writer.sv
// Character-LCD byte writer: sends a byte as two timed nibbles (or one init nibble).
// Optional macro LCD_LONG_CMD_EN stretches the execution wait for clear/home commands.
module lcd_byte_writer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 50,
    parameter int T_WAIT  = 2000,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 17
) (
    input  logic             clk,
    input  logic             rst,
    lcd_byte_writer_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_H,
        ST_PULSE_H,
        ST_HOLD_H,
        ST_GAP,
        ST_SETUP_L,
        ST_PULSE_L,
        ST_HOLD_L,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Each timed state leaves when the counter reaches its duration minus one.
    localparam logic [CNT_W-1:0] LIM_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LIM_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LIM_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LIM_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LIM_WAIT  = CNT_W'(T_WAIT - 1);
    localparam logic [CNT_W-1:0] LIM_LONG  = CNT_W'(T_LONG - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] limit;
    logic             at_end;

    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;
    logic             nib_reg, nib_next;
    logic             long_reg, long_next;
    logic             long_cmd;

    logic             lcd_e_reg, lcd_e_next;
    logic             lcd_rs_reg, lcd_rs_next;
    logic [3:0]       lcd_db_reg, lcd_db_next;
    logic             busy_reg, busy_next;
    logic             finish_reg, finish_next;

`ifdef LCD_LONG_CMD_EN
    // Clear (01) and return-home (02/03) need a much longer execution time.
    assign long_cmd = ~bus.rs_in &&
                      ((bus.data_in == 8'h01) || (bus.data_in == 8'h02) || (bus.data_in == 8'h03));
`else
    assign long_cmd = 1'b0;
`endif

    always_comb begin
        limit = '0;
        case (state_reg)
            ST_SETUP_H, ST_SETUP_L: limit = LIM_SETUP;
            ST_PULSE_H, ST_PULSE_L: limit = LIM_PULSE;
            ST_HOLD_H,  ST_HOLD_L:  limit = LIM_HOLD;
            ST_GAP:                 limit = LIM_GAP;
            ST_WAIT:                limit = long_reg ? LIM_LONG : LIM_WAIT;
            default:                limit = '0;
        endcase
    end

    assign at_end = (cnt_reg == limit);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        rs_next    = rs_reg;
        data_next  = data_reg;
        nib_next   = nib_reg;
        long_next  = long_reg;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (bus.wr_enable) begin
                    rs_next    = bus.rs_in;
                    data_next  = bus.data_in;
                    nib_next   = bus.nibble_only;
                    long_next  = long_cmd;
                    state_next = ST_SETUP_H;
                end
            end
            ST_SETUP_H: if (at_end) state_next = ST_PULSE_H;
            ST_PULSE_H: if (at_end) state_next = ST_HOLD_H;
            ST_HOLD_H:  if (at_end) state_next = nib_reg ? ST_WAIT : ST_GAP;
            ST_GAP:     if (at_end) state_next = ST_SETUP_L;
            ST_SETUP_L: if (at_end) state_next = ST_PULSE_L;
            ST_PULSE_L: if (at_end) state_next = ST_HOLD_L;
            ST_HOLD_L:  if (at_end) state_next = ST_WAIT;
            ST_WAIT:    if (at_end) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        lcd_e_next  = (state_next == ST_PULSE_H) || (state_next == ST_PULSE_L);
        lcd_rs_next = lcd_rs_reg;
        lcd_db_next = lcd_db_reg;
        case (state_next)
            ST_SETUP_H, ST_PULSE_H, ST_HOLD_H, ST_GAP: begin
                lcd_rs_next = rs_next;
                lcd_db_next = data_next[7:4];
            end
            ST_SETUP_L, ST_PULSE_L, ST_HOLD_L: begin
                lcd_rs_next = rs_next;
                lcd_db_next = data_next[3:0];
            end
            default: begin
                lcd_rs_next = lcd_rs_reg;
                lcd_db_next = lcd_db_reg;
            end
        endcase
        busy_next   = (state_next != ST_IDLE);
        finish_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            rs_reg     <= 1'b0;
            data_reg   <= '0;
            nib_reg    <= 1'b0;
            long_reg   <= 1'b0;
            lcd_e_reg  <= 1'b0;
            lcd_rs_reg <= 1'b0;
            lcd_db_reg <= '0;
            busy_reg   <= 1'b0;
            finish_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rs_reg     <= rs_next;
            data_reg   <= data_next;
            nib_reg    <= nib_next;
            long_reg   <= long_next;
            lcd_e_reg  <= lcd_e_next;
            lcd_rs_reg <= lcd_rs_next;
            lcd_db_reg <= lcd_db_next;
            busy_reg   <= busy_next;
            finish_reg <= finish_next;
        end
    end

    assign bus.lcd_e     = lcd_e_reg;
    assign bus.lcd_rs    = lcd_rs_reg;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_db    = lcd_db_reg;
    assign bus.busy      = busy_reg;
    assign bus.wr_finish = finish_reg;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: table vectors, hand sequences for
// reset/back-to-back/abort, and randomized writes against a timing-rule model.
`timescale 1ns/1ps
module tb_lcd_byte_writer;

    localparam int T_SETUP = 2;
    localparam int T_PULSE = 12;
    localparam int T_HOLD  = 1;
    localparam int T_GAP   = 50;
    localparam int T_WAIT  = 2000;
    localparam int T_LONG  = 82000;
    localparam int HALF    = T_SETUP + T_PULSE + T_HOLD;
`ifdef LCD_LONG_CMD_EN
    localparam bit LONG_EN   = 1'b1;
    localparam int N_RAND    = 0;
    localparam int CLR_DONE  = 82081;
`else
    localparam bit LONG_EN   = 1'b0;
    localparam int N_RAND    = 8;
    localparam int CLR_DONE  = 2081;
`endif

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic       nib;
        int         pulses;
        logic [3:0] db_hi;
        logic [3:0] db_lo;
        int         done_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    lcd_byte_writer_if bus();

    lcd_byte_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         st_pulses, st_fin_cnt, st_fin_first, st_fin_last, st_unstable, st_mism, st_bad_k;
    logic [3:0] st_db [4];
    logic [8:0] st_bad_act, st_bad_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp_v);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        if (LONG_EN && !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_LONG;
        return T_WAIT;
    endfunction

    function automatic int done_of(input logic nib, input int w);
        return nib ? 1 + HALF + w : 1 + 2 * HALF + T_GAP + w;
    endfunction

    // Expected {busy, wr_finish, lcd_e, lcd_rs, lcd_rw, lcd_db} in cycle k after capture edge 0.
    function automatic logic [8:0] model(input int k, input logic rs, input logic [7:0] d, input logic nib);
        int         lo0, done;
        logic       e;
        logic [3:0] db;
        lo0  = HALF + T_GAP + 1;
        done = done_of(nib, wait_of(rs, d));
        e    = (k >= 1 + T_SETUP && k <= T_SETUP + T_PULSE) ||
               (!nib && k >= lo0 + T_SETUP && k < lo0 + T_SETUP + T_PULSE);
        db   = (nib || k < lo0) ? d[7:4] : d[3:0];
        return {(k <= done), (k == done), e, rs, 1'b0, db};
    endfunction

    // Caller is at a negedge with rst released; the next posedge captures the write.
    task automatic run_write(input string tag, input logic rs, input logic [7:0] d, input logic nib,
                             input bit chain, input logic rs2, input logic [7:0] d2, input logic nib2);
        int         d1c, d2c, off2, span;
        logic [8:0] act, exp_v;
        logic       prev_e;
        logic [3:0] prev_db;
        d1c  = done_of(nib, wait_of(rs, d));
        d2c  = done_of(nib2, wait_of(rs2, d2));
        off2 = chain ? d1c + 1 : 0;
        span = chain ? off2 + d2c + 2 : d1c + 2;
        st_pulses = 0; st_fin_cnt = 0; st_fin_first = -1; st_fin_last = -1;
        st_unstable = 0; st_mism = 0; st_bad_k = 0; st_bad_act = '0; st_bad_exp = '0;
        for (int i = 0; i < 4; i++) st_db[i] = 4'h0;
        prev_e = 1'b0; prev_db = 4'h0;

        bus.rs_in = rs; bus.data_in = d; bus.nibble_only = nib; bus.wr_enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            act   = {bus.busy, bus.wr_finish, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_db};
            exp_v = (chain && k > off2) ? model(k - off2, rs2, d2, nib2) : model(k, rs, d, nib);
            if (act !== exp_v) begin
                if (st_mism == 0) begin
                    st_bad_k = k; st_bad_act = act; st_bad_exp = exp_v;
                end
                st_mism++;
            end
            if (bus.lcd_e === 1'b1 && prev_e !== 1'b1) begin
                if (st_pulses < 4) st_db[st_pulses] = bus.lcd_db;
                st_pulses++;
            end
            if (bus.lcd_e === 1'b1 && prev_e === 1'b1 && bus.lcd_db !== prev_db) st_unstable++;
            if (bus.wr_finish === 1'b1) begin
                if (st_fin_cnt == 0) st_fin_first = k;
                st_fin_last = k;
                st_fin_cnt++;
            end
            prev_e  = bus.lcd_e;
            prev_db = bus.lcd_db;

            // Stimulus for edge k: noise while busy, which the DUT must ignore.
            if (k < d1c) begin
                bus.wr_enable   = chain ? 1'(k % 2) : 1'($urandom_range(0, 1));
                bus.rs_in       = 1'($urandom);
                bus.data_in     = 8'($urandom);
                bus.nibble_only = 1'($urandom);
            end else if (chain && k <= off2) begin
                bus.wr_enable = 1'b1; bus.rs_in = rs2; bus.data_in = d2; bus.nibble_only = nib2;
            end else if (chain && k < off2 + d2c) begin
                bus.wr_enable = 1'($urandom_range(0, 1));
                bus.data_in   = 8'($urandom);
            end else begin
                bus.wr_enable = 1'b0;
            end
        end

        total++;
        if (st_mism != 0) begin
            bad++;
            $display("FAIL %s trace: cycle %0d actual=%h required=%h (%0d cycles differ)",
                     tag, st_bad_k, st_bad_act, st_bad_exp, st_mism);
        end else begin
            $display("ok   %s trace: %0d cycles match", tag, span);
        end
        check($sformatf("%s db_stable_while_e", tag), st_unstable, 0);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check($sformatf("%s pulses", tag), st_pulses, v.pulses);
        check($sformatf("%s db_hi", tag), {28'd0, st_db[0]}, {28'd0, v.db_hi});
        if (v.pulses == 2) check($sformatf("%s db_lo", tag), {28'd0, st_db[1]}, {28'd0, v.db_lo});
        check($sformatf("%s finish_cycle", tag), st_fin_first, v.done_cyc);
        check($sformatf("%s finish_count", tag), st_fin_cnt, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [4];
        vec_t v41;
        int   n_fin, n_e;
        logic       r, nn;
        logic [7:0] dd;

        vecs[0] = '{1'b0, 8'h01, 1'b0, 2, 4'h0, 4'h1, CLR_DONE};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 2, 4'h0, 4'h1, 2081};
        vecs[2] = '{1'b0, 8'h30, 1'b1, 1, 4'h3, 4'h3, 2016};
        vecs[3] = '{1'b0, 8'hA7, 1'b0, 2, 4'hA, 4'h7, 2081};
        v41     = '{1'b1, 8'h41, 1'b0, 2, 4'h4, 4'h1, 2081};

        // Reset held with a pending request: everything stays low.
        rst = 1'b0;
        bus.wr_enable = 1'b1; bus.rs_in = 1'b1; bus.data_in = 8'h41; bus.nibble_only = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_%0d", i),
                  {23'd0, bus.busy, bus.wr_finish, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_db}, 0);
        end
        rst = 1'b1;
        run_write("data_41", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_vec("data_41", v41);

`ifndef LCD_LONG_CMD_EN
        run_write("b2b", 1'b0, 8'h28, 1'b0, 1'b1, 1'b0, 8'h0C, 1'b0);
        check("b2b pulses", st_pulses, 4);
        check("b2b finish_count", st_fin_cnt, 2);
        check("b2b finish1", st_fin_first, 2081);
        check("b2b finish2", st_fin_last, 4163);
        check("b2b db_pulse3", {28'd0, st_db[2]}, 0);
        check("b2b db_pulse4", {28'd0, st_db[3]}, 12);
`endif

        // Abort in the middle of the lower E pulse.
        bus.rs_in = 1'b1; bus.data_in = 8'h55; bus.nibble_only = 1'b0; bus.wr_enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            bus.wr_enable = 1'b0;
        end
        check("abort e_before", {31'd0, bus.lcd_e}, 1);
        rst = 1'b0;
        @(negedge clk);
        check("abort e_after", {31'd0, bus.lcd_e}, 0);
        check("abort busy_after", {31'd0, bus.busy}, 0);
        rst = 1'b1;
        n_fin = 0; n_e = 0;
        for (int k = 0; k < 2100; k++) begin
            @(negedge clk);
            if (bus.wr_finish !== 1'b0) n_fin++;
            if (bus.lcd_e !== 1'b0) n_e++;
        end
        check("abort no_finish", n_fin, 0);
        check("abort no_e", n_e, 0);

        for (int i = 0; i < 4; i++) begin
            run_write($sformatf("vec%0d", i), vecs[i].rs, vecs[i].d, vecs[i].nib,
                      1'b0, 1'b0, 8'h00, 1'b0);
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < N_RAND; i++) begin
            r  = 1'($urandom);
            dd = 8'($urandom);
            nn = ($urandom_range(0, 3) == 0);
            if (!r && dd >= 8'h01 && dd <= 8'h03) dd = dd | 8'h10;
            run_write($sformatf("rand%0d", i), r, dd, nn, 1'b0, 1'b0, 8'h00, 1'b0);
            check($sformatf("rand%0d finish_cycle", i), st_fin_first, done_of(nn, wait_of(r, dd)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
- Responder end of the LCD write handshake. The init/refresh sequencer drives wr_enable with a command or data byte; this block drives the character LCD's 4-bit bus and returns a one-cycle wr_finish.
- Sends the byte as two nibbles, upper first. An init-time single-nibble mode is also supported.
- Enforces E setup, pulse width, hold, the inter-nibble gap and the post-write execution delay, all counted in clk cycles (50 MHz nominal).

Parameters:
- T_SETUP, 2: cycles RS/DB are stable before E rises.
- T_PULSE, 12: cycles E is held high.
- T_HOLD, 1: cycles RS/DB are held after E falls.
- T_GAP, 50: idle cycles between the upper and lower nibble.
- T_WAIT, 2000: execution delay after the last nibble, before completion.
- T_LONG, 82000: execution delay for clear/home commands; used only with the optional feature.
- CNT_W, 17: delay counter width. Must hold max(T_*) - 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_enable  in  1  write request; sampled only in IDLE.
- rs_in  in  1  0 = command, 1 = data; captured with the request.
- data_in  in  8  byte to write; captured with the request.
- nibble_only  in  1  1 = send data_in[7:4] only (init sequence); captured with the request.
- busy  out  1  high from the capture cycle's next cycle through the DONE cycle.
- wr_finish  out  1  one-cycle completion pulse.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; constant 0 (write-only block).
- lcd_db  out  4  LCD data nibble (DB7..DB4).

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, counter=0. lcd_e, lcd_rs, lcd_rw, lcd_db, wr_finish and busy all = 0. Reset mid-write aborts immediately: lcd_e drops on that same edge, no wr_finish is issued.
- States: IDLE, SETUP_H, PULSE_H, HOLD_H, GAP, SETUP_L, PULSE_L, HOLD_L, WAIT, DONE.
- All outputs are registered.
- Each timed state lasts exactly its T_* cycles. The counter loads 0 on state entry and the state exits when counter = T_x - 1.
- IDLE: when wr_enable=1, capture rs_in, data_in and nibble_only, then go to SETUP_H. Otherwise stay. wr_enable is ignored in every other state; no queuing.
- SETUP_H: lcd_db=data[7:4], lcd_rs=rs, lcd_e=0.
- PULSE_H: same lcd_db/lcd_rs, lcd_e=1.
- HOLD_H: same lcd_db/lcd_rs, lcd_e=0.
- After HOLD_H: go to WAIT if nibble_only=1, else to GAP.
- GAP: lcd_e=0, lcd_db/lcd_rs held.
- SETUP_L / PULSE_L / HOLD_L: as the _H states, with lcd_db=data[3:0].
- WAIT: lcd_e=0, lcd_db and lcd_rs hold their last values, duration T_WAIT.
- DONE: wr_finish=1 for exactly one cycle, then return to IDLE. busy=0 from the cycle after DONE.
- Latency, with capture at edge 0:
  - full byte: wr_finish is high in cycle 1 + 2*(T_SETUP+T_PULSE+T_HOLD) + T_GAP + T_WAIT;
  - nibble_only: wr_finish is high in cycle 1 + T_SETUP + T_PULSE + T_HOLD + T_WAIT.
- wr_enable held high through DONE: a new write is accepted on the first IDLE cycle, so back-to-back writes have exactly one IDLE cycle between DONE and the next SETUP_H.
- lcd_e is never high outside PULSE_H and PULSE_L. lcd_db and lcd_rs never change while lcd_e=1.

Optional Feature:
- Macro LCD_LONG_CMD_EN.
- Defined: if rs=0 and the captured byte is 8'h01 (clear) or 8'h02/8'h03 (home), WAIT lasts T_LONG cycles instead of T_WAIT. All other writes use T_WAIT.
- Undefined: WAIT always lasts T_WAIT. The caller must insert its own delay after clear/home.

Test Plan:
- Reset: hold rst=0 for 3 cycles with wr_enable=1 -> all outputs 0, busy=0, no E pulse. Release rst with wr_enable=1 -> busy=1 the next cycle.
- Data write: rs_in=1, data_in=8'h41, default parameters -> lcd_db=4'h4 during E-high cycles 3-14; lcd_db=4'h1 during E-high cycles 68-79; lcd_rs=1 throughout; wr_finish high only in cycle 2081.
- Nibble-only init: rs_in=0, data_in=8'h30, nibble_only=1 -> exactly one E pulse, lcd_db=4'h3; wr_finish in cycle 2016; busy=0 in cycle 2017.
- Back-to-back: wr_enable held high for two writes (8'h28, then 8'h0C) -> the second SETUP_H starts 2 cycles after the first wr_finish; a wr_enable toggled mid-write is ignored (exactly 4 E pulses in total).
- Abort: assert rst=0 during PULSE_L of a write -> lcd_e=0 on the next edge, no wr_finish; a following 8'h01 write completes normally.
- LCD_LONG_CMD_EN defined: command 8'h01 -> wr_finish in cycle 1+30+50+82000=82081. Data byte 8'h01 with rs=1 -> cycle 2081. Macro undefined: command 8'h01 -> cycle 2081.
